subtractor_ripple_serial_u: RTL and testbench



---
 rtl/subtractor_ripple_serial_u_if.sv | 44 ++++
 rtl/subtractor_ripple_serial_u.sv | 170 +++++++++++++++++
 tb/tb_subtractor_ripple_serial_u.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subtractor_ripple_serial_u_if.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_ripple_serial_u_if
// Purpose  : Operand/result handshake bundle for the serial subtractor.
//            master = producer of operands / consumer of results,
//            slave  = the subtractor itself.
// Signals  : in_valid/in_ready/a/b     operand channel
//            out_valid/out_ready/diff/bout result channel
//            ovf (only with SUB_SIGNED_OVF_EN) signed overflow flag
// Macro    : SUB_SIGNED_OVF_EN adds the ovf signal.
// Revision : 1.0 - initial release
// ============================================================================
interface subtractor_ripple_serial_u_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef SUB_SIGNED_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef SUB_SIGNED_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/subtractor_ripple_serial_u.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_ripple_serial_u
// Purpose  : Multi-cycle unsigned subtractor, diff = a - b (mod 2^WIDTH) and
//            bout = (a < b). Resolves DIGIT bits per clock, LSB first, with
//            the borrow carried between clocks.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous reset, active high
//            bus  - slave side of subtractor_ripple_serial_u_if
//                   (in_valid/in_ready/a/b in, out_valid/out_ready/diff/bout
//                   out, plus ovf when enabled)
// Macro    : SUB_SIGNED_OVF_EN - adds two's-complement overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_ripple_serial_u #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  wire                           clk,
    input  wire                           rst,
    subtractor_ripple_serial_u_if.slave   bus
);

    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_CNT_W = $clog2(c_N + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;

    logic [DIGIT-1:0]   w_d;
    logic               w_digit_bout;
    logic [WIDTH+DIGIT-1:0] w_cat;

    logic               w_in_ready;
    logic               w_out_valid;

    // ------------------------------------------------------------------
    // One digit of ripple-borrow subtraction on the low bits of the
    // operand shift registers, borrow-in from the previous clock.
    // ------------------------------------------------------------------
    always_comb begin
        logic bin;
        bin = r_borrow;
        w_d = '0;
        for (int i = 0; i < DIGIT; i++) begin
            w_d[i] = r_a[i] ^ r_b[i] ^ bin;
            bin    = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & bin);
        end
        w_digit_bout = bin;
    end

    // New digit enters at the MSB side; the result register shifts right so
    // that after N steps the first digit has reached bit 0. Concatenating
    // first keeps this well-formed even when DIGIT == WIDTH.
    assign w_cat = {w_d, r_res};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, serial step, result hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_res    <= w_cat[WIDTH+DIGIT-1:DIGIT];
                    r_borrow <= w_digit_bout;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: begin
                    // DONE: result and borrow are held for the consumer.
                end
            endcase
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep a copy.
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (r_state == ST_IDLE && bus.in_valid) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end
    end

    assign bus.ovf = (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.diff      = r_res;
    assign bus.bout      = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_ripple_serial_u.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_ripple_serial_u
// Purpose  : Self-checking bench for subtractor_ripple_serial_u. Drives a
//            4-bit/1-digit instance and an 8-bit/4-digit instance with
//            directed vectors and a random back-to-back stream.
// Macro    : SUB_SIGNED_OVF_EN enables the ovf checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_ripple_serial_u;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    subtractor_ripple_serial_u_if #(.WIDTH(4)) s4 ();
    subtractor_ripple_serial_u_if #(.WIDTH(8)) s8 ();

    subtractor_ripple_serial_u #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (s4)
    );

    subtractor_ripple_serial_u #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Operand handshake on the 4-bit instance; returns at the negedge
    // following the capturing edge.
    task automatic send4(input logic [3:0] a, input logic [3:0] b);
        int guard = 0;
        @(negedge clk);
        while (!s4.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s4.in_ready) begin
            checks++; errors++;
            $display("FAIL send4_timeout: in_ready=%0b required 1", s4.in_ready);
        end
        s4.in_valid = 1'b1; s4.a = a; s4.b = b;
        @(negedge clk);
        s4.in_valid = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!s4.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (!s8.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s8.in_ready) begin
            checks++; errors++;
            $display("FAIL send8_timeout: in_ready=%0b required 1", s8.in_ready);
        end
        s8.in_valid = 1'b1; s8.a = a; s8.b = b;
        @(negedge clk);
        s8.in_valid = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!s8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (s4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %0b want 1", s4.in_ready); end
        checks++; if (s4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %0b want 0", s4.out_valid); end
        checks++; if (s4.diff !== 4'd0) begin errors++; $display("FAIL reset_diff4: got %0d want 0", s4.diff); end
        checks++; if (s4.bout !== 1'b0) begin errors++; $display("FAIL reset_bout4: got %0b want 0", s4.bout); end
        checks++; if (s8.in_ready !== 1'b1 || s8.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs8: in_ready=%0b out_valid=%0b want 1/0", s8.in_ready, s8.out_valid);
        end
        checks++; if (s8.diff !== 8'd0 || s8.bout !== 1'b0) begin
            errors++; $display("FAIL reset_res8: diff=%0h bout=%0b want 0/0", s8.diff, s8.bout);
        end
`ifdef SUB_SIGNED_OVF_EN
        checks++; if (s4.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf4: got %0b want 0", s4.ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        // {a, b, diff, bout}
        logic [12:0] vec [4] = '{
            {4'd9,  4'd3,  4'd6,  1'b0},
            {4'd3,  4'd9,  4'd10, 1'b1},
            {4'd0,  4'd1,  4'd15, 1'b1},
            {4'd15, 4'd15, 4'd0,  1'b0}
        };
        s4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] va, vb, vd;
            logic       vbo;
            int         lat;
            {va, vb, vd, vbo} = vec[i];
            send4(va, vb);
            wait4(lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency[%0d]: got %0d edges want 4", i, lat); end
            checks++; if (s4.out_valid !== 1'b1 || s4.diff !== vd || s4.bout !== vbo) begin
                errors++; $display("FAIL basic_result[%0d] %0d-%0d: valid=%0b diff=%0d bout=%0b want 1/%0d/%0b",
                                   i, va, vb, s4.out_valid, s4.diff, s4.bout, vd, vbo);
            end
            checks++; if (s4.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done[%0d]: got %0b want 0", i, s4.in_ready); end
`ifdef SUB_SIGNED_OVF_EN
            checks++; if (s4.ovf !== ((va[3] != vb[3]) && (vd[3] != va[3]))) begin
                errors++; $display("FAIL basic_ovf[%0d]: got %0b want %0b", i, s4.ovf, (va[3] != vb[3]) && (vd[3] != va[3]));
            end
`endif
            @(negedge clk);
            checks++; if (s4.out_valid !== 1'b0 || s4.in_ready !== 1'b1) begin
                errors++; $display("FAIL basic_release[%0d]: out_valid=%0b in_ready=%0b want 0/1", i, s4.out_valid, s4.in_ready);
            end
        end
    endtask

`ifdef SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        int lat;
        s4.out_ready = 1'b1;
        send4(4'd8, 4'd1);
        wait4(lat);
        checks++; if (s4.diff !== 4'd7 || s4.bout !== 1'b0 || s4.ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_8m1: diff=%0d bout=%0b ovf=%0b want 7/0/1", s4.diff, s4.bout, s4.ovf);
        end
        @(negedge clk);
        send4(4'd7, 4'd15);
        wait4(lat);
        checks++; if (s4.diff !== 4'd8 || s4.bout !== 1'b1 || s4.ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_7m15: diff=%0d bout=%0b ovf=%0b want 8/1/1", s4.diff, s4.bout, s4.ovf);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_backpressure();
        int lat;
        s4.out_ready = 1'b0;
        send4(4'd5, 4'd2);
        // Stray operands while busy must not be captured.
        s4.in_valid = 1'b1; s4.a = 4'd1; s4.b = 4'd1;
        @(negedge clk);
        s4.in_valid = 1'b0;
        wait4(lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin s4.in_valid = 1'b1; s4.a = 4'd1; s4.b = 4'd1; end
            if (i == 5) s4.in_valid = 1'b0;
            checks++; if (s4.out_valid !== 1'b1 || s4.diff !== 4'd3 || s4.bout !== 1'b0 || s4.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%0b diff=%0d bout=%0b in_ready=%0b want 1/3/0/0",
                                   i, s4.out_valid, s4.diff, s4.bout, s4.in_ready);
            end
            @(negedge clk);
        end
        s4.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (s4.out_valid !== 1'b0 || s4.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0/1", s4.out_valid, s4.in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        s4.out_ready = 1'b1;
        send4(4'd9, 4'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (s4.in_ready !== 1'b1 || s4.out_valid !== 1'b0 || s4.diff !== 4'd0 || s4.bout !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run: in_ready=%0b out_valid=%0b diff=%0d bout=%0b want 1/0/0/0",
                               s4.in_ready, s4.out_valid, s4.diff, s4.bout);
        end
        @(negedge clk);
        rst = 1'b0;
        send4(4'd12, 4'd5);
        wait4(lat);
        checks++; if (s4.out_valid !== 1'b1 || s4.diff !== 4'd7 || s4.bout !== 1'b0) begin
            errors++; $display("FAIL after_reset_12m5: valid=%0b diff=%0d bout=%0b want 1/7/0", s4.out_valid, s4.diff, s4.bout);
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        // {a, b, diff, bout}
        logic [24:0] vec [3] = '{
            {8'h10, 8'h01, 8'h0F, 1'b0},
            {8'h00, 8'hFF, 8'h01, 1'b1},
            {8'hA5, 8'hA5, 8'h00, 1'b0}
        };
        s8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] va, vb, vd;
            logic       vbo;
            int         lat;
            {va, vb, vd, vbo} = vec[i];
            send8(va, vb);
            wait8(lat);
            checks++; if (lat !== 2) begin errors++; $display("FAIL wide_latency[%0d]: got %0d edges want 2", i, lat); end
            checks++; if (s8.out_valid !== 1'b1 || s8.diff !== vd || s8.bout !== vbo) begin
                errors++; $display("FAIL wide_result[%0d] %0h-%0h: valid=%0b diff=%0h bout=%0b want 1/%0h/%0b",
                                   i, va, vb, s8.out_valid, s8.diff, s8.bout, vd, vbo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] q [$];
        logic [8:0] exp;
        logic [7:0] ra, rb;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        s8.out_ready = 1'b1;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (s8.out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_spurious: out_valid=1 with nothing outstanding");
                end else begin
                    exp = q.pop_front();
                    checks++; if ({s8.bout, s8.diff} !== exp) begin
                        errors++; $display("FAIL b2b[%0d]: bout=%0b diff=%0h want %0b/%0h",
                                           got, s8.bout, s8.diff, exp[8], exp[7:0]);
                    end
                end
                got++;
            end
            if (s8.in_ready && sent < 1000) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                s8.a = ra; s8.b = rb; s8.in_valid = 1'b1;
                q.push_back({1'b0, ra} - {1'b0, rb});
                sent++;
            end else if (sent >= 1000) begin
                s8.in_valid = 1'b0;
            end
        end
        s8.in_valid = 1'b0;
        if (got < 1000) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: got %0d results want 1000", got);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        s4.in_valid = 1'b0; s4.a = '0; s4.b = '0; s4.out_ready = 1'b1;
        s8.in_valid = 1'b0; s8.a = '0; s8.b = '0; s8.out_ready = 1'b1;

        test_reset();
        test_basic();
`ifdef SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        test_backpressure();
        test_reset_mid_run();
        test_wide();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
